// File: rtl/wm_block_sched_pkg.sv
// Shared constants and state encoding for the watermark block scheduler.
package wm_pkg;

    localparam int unsigned CTRL_ADDR    = 32'h00;
    localparam int unsigned PRIMARY_SIZE = 32'h02;
    localparam int unsigned WM_SIZE      = 32'h03;
    localparam int unsigned BLOCK_SIZE   = 32'h04;
    localparam int unsigned PIXEL_BASE   = 32'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_CHECK,
        S_FETCH,
        S_PRESENT,
        S_CLEAR,
        S_FIN
    } sched_state_e;

endpackage

// File: rtl/wm_block_sched_addr_gen.sv
// Block-scan counters (c, r, bc, br) and the bank address of the current pixel.
// Block counters wrap on >= Np (or on no progress) so a bad geometry still ends.
module wm_addr_gen
    import wm_pkg::*;
#(
    parameter int AW = 21
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          step_i,
    input  logic          phase_i,
    input  logic [AW-1:0] np_i,
    input  logic [AW-1:0] m_i,
    input  logic [AW-1:0] npsq_i,
    output logic [AW-1:0] addr_o,
    output logic          first_o,
    output logic          last_o,
    output logic          blk_end_o,
    output logic          scan_end_o
);

    localparam logic [AW-1:0] ONE = AW'(1);

    logic [AW-1:0] r_q, c_q, bc_q, br_q;
    logic [AW-1:0] r_inc, c_inc, bc_inc, br_inc;
    logic          r_wrap, c_wrap, bc_wrap, br_wrap;

    always_comb begin
        c_inc   = c_q + ONE;
        r_inc   = r_q + ONE;
        bc_inc  = bc_q + m_i;
        br_inc  = br_q + m_i;
        c_wrap  = c_inc >= m_i;
        r_wrap  = r_inc >= m_i;
        bc_wrap = (bc_inc >= np_i) || (bc_inc <= bc_q);
        br_wrap = (br_inc >= np_i) || (br_inc <= br_q);
    end

    assign first_o    = (r_q == '0) && (c_q == '0);
    assign last_o     = (r_q == m_i - ONE) && (c_q == m_i - ONE);
    assign blk_end_o  = c_wrap && r_wrap;
    assign scan_end_o = phase_i && blk_end_o && bc_wrap && br_wrap;
    assign addr_o     = AW'(PIXEL_BASE) + (phase_i ? npsq_i : '0)
                      + (br_q + r_q) * np_i + bc_q + c_q;

    // Block position only moves after the watermark pass of the block.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q  <= '0;
            c_q  <= '0;
            bc_q <= '0;
            br_q <= '0;
        end else if (clear_i) begin
            r_q  <= '0;
            c_q  <= '0;
            bc_q <= '0;
            br_q <= '0;
        end else if (step_i) begin
            c_q <= c_wrap ? '0 : c_inc;
            if (c_wrap) begin
                r_q <= r_wrap ? '0 : r_inc;
                if (r_wrap && phase_i) begin
                    bc_q <= bc_wrap ? '0 : bc_inc;
                    if (bc_wrap)
                        br_q <= br_wrap ? '0 : br_inc;
                end
            end
        end
    end

endmodule

// File: rtl/wm_block_sched.sv
// Block scheduler: reads geometry, streams primary then watermark pixels per MxM block.
// Define WM_SCHED_CFG_CHECK_EN to build the geometry CHECK state and the err flag.
module wm_block_sched
    import wm_pkg::*;
#(
    parameter int Amba_Word       = 16,
    parameter int Amba_Addr_Depth = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [Amba_Addr_Depth:0] bank_addr,
    output logic                     bank_we,
    output logic [Amba_Word-1:0]     bank_wdata,
    input  logic [Amba_Word-1:0]     bank_rdata,
    output logic [Amba_Word-1:0]     pix_data,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic                     pix_sel,
    output logic                     blk_first,
    output logic                     blk_last,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int AW = Amba_Addr_Depth + 1;

    sched_state_e   state_q, state_d;
    logic [1:0]     cfg_cnt_q;
    logic [AW-1:0]  np_q, m_q, npsq_q;
    logic           phase_q;
    logic [Amba_Word-1:0] pix_data_q;
    logic           pix_valid_q, pix_sel_q, blk_first_q, blk_last_q;
    logic           bank_we_q, done_q;
    logic           step;
    logic [AW-1:0]  gen_addr;
    logic           gen_first, gen_last, gen_blk_end, gen_scan_end;

`ifdef WM_SCHED_CFG_CHECK_EN
    logic [AW-1:0]  nw_q, rem_q;
    logic           err_q, err_set;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign step = (state_q == S_PRESENT) && pix_ready;

    wm_addr_gen #(.AW(AW)) u_addr_gen (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (state_q == S_CFG),
        .step_i     (step),
        .phase_i    (phase_q),
        .np_i       (np_q),
        .m_i        (m_q),
        .npsq_i     (npsq_q),
        .addr_o     (gen_addr),
        .first_o    (gen_first),
        .last_o     (gen_last),
        .blk_end_o  (gen_blk_end),
        .scan_end_o (gen_scan_end)
    );

    always_comb begin
        state_d = state_q;
`ifdef WM_SCHED_CFG_CHECK_EN
        err_set = 1'b0;
`endif
        case (state_q)
            S_IDLE:    if (start) state_d = S_CFG;
`ifdef WM_SCHED_CFG_CHECK_EN
            S_CFG:     if (cfg_cnt_q == 2'd3) state_d = S_CHECK;
            // One subtraction per cycle; the final cycle judges the remainder.
            S_CHECK: begin
                if (m_q == '0 || nw_q != np_q) begin
                    err_set = 1'b1;
                    state_d = S_CLEAR;
                end else if (rem_q < m_q) begin
                    if (rem_q != '0) begin
                        err_set = 1'b1;
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
`else
            S_CFG:     if (cfg_cnt_q == 2'd3) state_d = S_FETCH;
`endif
            S_FETCH:   state_d = start ? S_PRESENT : S_IDLE;
            S_PRESENT: if (pix_ready) state_d = gen_scan_end ? S_CLEAR : S_FETCH;
            S_CLEAR:   state_d = err ? S_IDLE : S_FIN;
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bank_addr = '0;
        if (state_q == S_CFG) begin
            case (cfg_cnt_q)
                2'd0:    bank_addr = AW'(PRIMARY_SIZE);
                2'd1:    bank_addr = AW'(WM_SIZE);
                2'd2:    bank_addr = AW'(BLOCK_SIZE);
                default: bank_addr = AW'(CTRL_ADDR);
            endcase
        end else if (state_q == S_FETCH) begin
            bank_addr = gen_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cfg_cnt_q   <= '0;
            np_q        <= '0;
            m_q         <= '0;
            npsq_q      <= '0;
            phase_q     <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_sel_q   <= 1'b0;
            blk_first_q <= 1'b0;
            blk_last_q  <= 1'b0;
            bank_we_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_cnt_q <= (state_q == S_CFG) ? cfg_cnt_q + 2'd1 : 2'd0;
            // Read data lands at the posedge closing the cycle its address was driven.
            if (state_q == S_CFG) begin
                case (cfg_cnt_q)
                    2'd0:    np_q   <= AW'(bank_rdata);
                    2'd2:    m_q    <= AW'(bank_rdata);
                    2'd3:    npsq_q <= np_q * np_q;
                    default: ;
                endcase
            end
            if (state_q == S_CFG)
                phase_q <= 1'b0;
            else if (step && gen_blk_end)
                phase_q <= ~phase_q;
            if (state_q == S_FETCH && start) begin
                pix_valid_q <= 1'b1;
                pix_data_q  <= bank_rdata;
                pix_sel_q   <= phase_q;
                blk_first_q <= gen_first;
                blk_last_q  <= gen_last;
            end else if (step) begin
                pix_valid_q <= 1'b0;
            end
            bank_we_q <= (state_d == S_CLEAR);
            done_q    <= (state_d == S_FIN);
        end
    end

`ifdef WM_SCHED_CFG_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nw_q  <= '0;
            rem_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_CFG && cfg_cnt_q == 2'd1)
                nw_q <= AW'(bank_rdata);
            if (state_q == S_CFG)
                rem_q <= np_q;
            else if (state_q == S_CHECK && rem_q >= m_q)
                rem_q <= rem_q - m_q;
            if (state_q == S_IDLE && start)
                err_q <= 1'b0;
            else if (err_set)
                err_q <= 1'b1;
        end
    end
`endif

    assign bank_we    = bank_we_q;
    assign bank_wdata = '0;
    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign pix_sel    = pix_sel_q;
    assign blk_first  = blk_first_q;
    assign blk_last   = blk_last_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_wm_block_sched.sv
// Scoreboard bench: a bank model, a scan-order reference queue and a decoupled pixel monitor.
module tb_wm_block_sched;

    localparam int AW = 21;

    logic          clk, rst, start;
    logic [AW-1:0] bank_addr;
    logic          bank_we;
    logic [15:0]   bank_wdata, bank_rdata, pix_data;
    logic          pix_valid, pix_ready, pix_sel, blk_first, blk_last, busy, done, err;

    typedef struct packed {
        logic [15:0] d;
        logic        sel;
        logic        first;
        logic        last;
    } pix_t;

    pix_t        exp_q[$];
    logic [15:0] mem [0:255];
    logic [15:0] ctrl;
    logic        host_wr;
    logic [15:0] host_val;
    logic [7:0]  salt;
    logic        rnd_ready;
    logic        prev_xfer, prev_stall;
    pix_t        held, cur;
    int          errors, checks, xfer_cnt, done_cnt, valid_cnt;

    wm_block_sched dut (
        .clk(clk), .rst(rst), .start(start),
        .bank_addr(bank_addr), .bank_we(bank_we), .bank_wdata(bank_wdata),
        .bank_rdata(bank_rdata),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sel(pix_sel), .blk_first(blk_first), .blk_last(blk_last),
        .busy(busy), .done(done), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign start = ctrl[0];

    // Bank: samples on negedge, read data valid by the following posedge.
    always @(negedge clk) begin
        if (host_wr)
            ctrl <= host_val;
        else if (bank_we && bank_addr == '0)
            ctrl <= bank_wdata;
        bank_rdata <= (bank_addr == '0) ? ctrl : mem[bank_addr[7:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pv(input int a);
        return {salt, 8'(a)};
    endfunction

    // Monitor: pops the reference on each handshake, checks hold and spacing.
    always @(negedge clk) begin
        cur = {pix_data, pix_sel, blk_first, blk_last};
        if (rst) begin
            prev_xfer  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (pix_valid) valid_cnt++;
            if (prev_xfer) chk("pix_spacing", 32'(pix_valid), 0);
            if (prev_stall) begin
                chk("stall_valid_held", 32'(pix_valid), 1);
                chk("stall_data_held", 32'(cur), 32'(held));
            end
            if (pix_valid && pix_ready) begin
                chk("pix_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("pixel", 32'(cur), 32'(exp_q.pop_front()));
                xfer_cnt++;
            end
            if (pix_valid && !pix_ready) held = cur;
            prev_xfer  = pix_valid && pix_ready;
            prev_stall = pix_valid && !pix_ready;
        end
    end

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic host_ctrl(input logic [15:0] v);
        @(posedge clk);
        #1 host_val = v;
        host_wr = 1'b1;
        @(negedge clk);
        #1 host_wr = 1'b0;
    endtask

    task automatic load_geom(input int np, input int nw, input int m);
        for (int a = 0; a < 256; a++) mem[a] = (a >= 10) ? pv(a) : 16'h0;
        mem[2] = 16'(np);
        mem[3] = 16'(nw);
        mem[4] = 16'(m);
    endtask

    // Reference scan straight from the block/phase/row/column ordering.
    task automatic build_expect(input int np, input int m);
        pix_t p;
        for (int br = 0; br + m <= np; br += m)
            for (int bc = 0; bc + m <= np; bc += m)
                for (int ph = 0; ph < 2; ph++)
                    for (int r = 0; r < m; r++)
                        for (int c = 0; c < m; c++) begin
                            p.d     = pv(10 + ph * np * np + (br + r) * np + bc + c);
                            p.sel   = 1'(ph);
                            p.first = (r == 0 && c == 0);
                            p.last  = (r == m - 1 && c == m - 1);
                            exp_q.push_back(p);
                        end
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        chk("busy_rise", 32'(busy), 1);
        n = 0;
        while (busy && n < 5000) begin @(negedge clk); n++; end
        chk("busy_fall", 32'(busy), 0);
    endtask

    task automatic run_scan(input int np, input int m, input logic rnd, input logic chk_lat);
        int d0, n, lat;
        load_geom(np, np, m);
        build_expect(np, m);
        rnd_ready = rnd;
        d0 = done_cnt;
        host_ctrl(16'h0001);
        if (chk_lat) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!pix_valid && n < 100);
`ifdef WM_SCHED_CFG_CHECK_EN
            lat = 6 + 1 + np / m;
`else
            lat = 6;
`endif
            chk("first_valid_latency", 32'(n), 32'(lat));
        end
        wait_run();
        rnd_ready = 1'b0;
        chk("queue_drained", 32'(exp_q.size()), 0);
        chk("done_pulses", 32'(done_cnt - d0), 1);
        chk("ctrl_cleared", 32'(ctrl), 0);
        chk("err_low", 32'(err), 0);
    endtask

`ifdef WM_SCHED_CFG_CHECK_EN
    task automatic run_err(input int np, input int nw, input int m);
        int d0, v0;
        logic exp_err;
        exp_err = (m == 0) || (nw != np) || (np % m != 0);
        load_geom(np, nw, m);
        d0 = done_cnt;
        v0 = valid_cnt;
        host_ctrl(16'h0001);
        wait_run();
        repeat (3) @(negedge clk);
        chk("cfg_err", 32'(err), 32'(exp_err));
        chk("err_ctrl_cleared", 32'(ctrl), 0);
        chk("err_no_valid", 32'(valid_cnt - v0), 0);
        chk("err_no_done", 32'(done_cnt - d0), 0);
    endtask
`endif

    initial begin
        int np, m, n, d0, x0;
        errors = 0; checks = 0; xfer_cnt = 0; done_cnt = 0; valid_cnt = 0;
        prev_xfer = 1'b0; prev_stall = 1'b0;
        rst = 1'b1; host_wr = 1'b1; host_val = 16'h0; rnd_ready = 1'b0;
        salt = 8'($urandom);
        load_geom(4, 4, 2);
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(|{bank_addr, bank_we, bank_wdata, pix_data, pix_valid,
                                  pix_sel, blk_first, blk_last, busy, done, err}), 0);
        #1 host_wr = 1'b0;
        @(negedge clk) rst = 1'b0;

        run_scan(4, 2, 1'b0, 1'b1);
        run_scan(4, 2, 1'b1, 1'b0);
        repeat (4) begin
            np = $urandom_range(1, 6);
            do m = $urandom_range(1, np); while (np % m != 0);
            run_scan(np, m, 1'b1, 1'b0);
        end

`ifdef WM_SCHED_CFG_CHECK_EN
        run_err(4, 4, 3);
        run_err(4, 2, 2);
        run_err(4, 4, 0);
        run_scan(4, 2, 1'b0, 1'b0);
`endif

        // Host abort after 5 pixels, then a clean restart.
        load_geom(4, 4, 2);
        build_expect(4, 2);
        d0 = done_cnt;
        x0 = xfer_cnt;
        host_ctrl(16'h0001);
        n = 0;
        while (xfer_cnt - x0 < 5 && n < 500) begin @(posedge clk); n++; end
        chk("abort_reached_5", 32'(xfer_cnt - x0 >= 5), 1);
        host_ctrl(16'h0000);
        n = 0;
        while (busy && n < 10) begin @(negedge clk); n++; end
        chk("abort_idle_late", 32'(n > 2), 0);
        repeat (4) @(negedge clk);
        chk("abort_stays_idle", 32'({busy, pix_valid}), 0);
        chk("abort_no_done", 32'(done_cnt - d0), 0);
        exp_q.delete();
        run_scan(4, 2, 1'b0, 1'b0);

        // Reset while a pixel is presented, then a full rescan.
        load_geom(4, 4, 2);
        build_expect(4, 2);
        d0 = done_cnt;
        host_ctrl(16'h0001);
        n = 0;
        while (!pix_valid && n < 100) begin @(negedge clk); n++; end
        chk("reached_present", 32'(pix_valid), 1);
        #2 rst = 1'b1;
        #1 chk("rst_outputs", 32'(|{bank_addr, bank_we, bank_wdata, pix_data, pix_valid,
                                   pix_sel, blk_first, blk_last, busy, done, err}), 0);
        host_ctrl(16'h0000);
        exp_q.delete();
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_idle", 32'(busy), 0);
        chk("rst_no_done", 32'(done_cnt - d0), 0);
        run_scan(4, 2, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
